// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller.
//   tx_state_e : frame sequencing states
//   CNT_W      : bit-period counter width (must hold 166667)
//   BAUD_DIV   : clock cycles per bit for each 4-bit baud code
//   baud_div() : baud code -> cycles-per-bit lookup
package uart_pkg;

  localparam int CNT_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  // Codes 1100-1111 are not real rates; they fall back to the 9600-baud divisor.
  localparam logic [CNT_W-1:0] BAUD_DIV [16] = '{
    18'd166667, 18'd41667, 18'd20833, 18'd10417,
    18'd5208,   18'd2604,  18'd1302,  18'd868,
    18'd434,    18'd217,   18'd109,   18'd54,
    18'd5208,   18'd5208,  18'd5208,  18'd5208
  };

  function automatic logic [CNT_W-1:0] baud_div(input logic [3:0] code);
    return BAUD_DIV[code];
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake for the UART transmitter.
//   tx_start : request valid (host -> tx)
//   tx_data  : byte to send   (host -> tx)
//   tx_ready : tx is idle and will accept a request (tx -> host)
interface uart_tx_ctrl_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_start, output tx_data, input tx_ready);
  modport slave  (input tx_start, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl_baud_period_cnt.sv
// Bit-period counter: counts 0..n-1 while run is high and flags the last
// cycle of each bit period. Held at zero while run is low.
//   clk, rstb : clock, async active-low reset
//   run       : count enable (high whenever a frame is in flight)
//   n         : cycles per bit, held stable for the whole frame
//   bit_tick  : high on the final cycle of a bit period
module baud_period_cnt #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             run,
  input  logic [CNT_W-1:0] n,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = run && (cnt == n - CNT_W'(1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (!run || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on the bus handshake and sends
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits on tx.
// Frame config and the bit period are latched at accept, so later input
// changes only affect the next frame.
//   clk, rstb   : clock, async active-low reset
//   bus         : tx_start / tx_data / tx_ready handshake (slave side)
//   baud_select : baud code, see uart_pkg::BAUD_DIV
//   parity_en   : append a parity bit
//   parity_odd  : odd (1) or even (0) parity
//   two_stop    : send two stop bits
//   busy        : frame in flight (cycle after accept until back in IDLE)
//   done        : one-cycle pulse in the first IDLE cycle after a frame
//   tx          : serial line, idles high
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (low)
// DATA   | data bits, LSB first, bit index in idx
// PARITY | parity bit
// STOP1  | first stop bit
// STOP2  | second stop bit (two_stop frames only)
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 18
) (
  input  logic                 clk,
  input  logic                 rstb,
  uart_tx_ctrl_if.slave        bus,
  input  logic [3:0]           baud_select,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);
  import uart_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_e        state;
  logic [7:0]       shreg;
  logic [2:0]       idx;
  logic [CNT_W-1:0] n_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             two_stop_q;
  logic             bit_tick;

  baud_period_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rstb     (rstb),
    .run      (state != IDLE),
    .n        (n_q),
    .bit_tick (bit_tick)
  );

  assign bus.tx_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      shreg      <= '0;
      idx        <= '0;
      n_q        <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_start) begin
            shreg      <= bus.tx_data;
            n_q        <= baud_div(baud_select);
            par_en_q   <= parity_en;
            // parity is fixed by the byte, so resolve it now rather than
            // tracking it while the shift register empties
            par_bit_q  <= (^bus.tx_data) ^ parity_odd;
            two_stop_q <= two_stop;
            idx        <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (idx == LAST_IDX) begin
              if (par_en_q) begin
                tx    <= par_bit_q;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP1;
              end
            end else begin
              shreg <= shreg >> 1;
              tx    <= shreg[1];
              idx   <= idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (bit_tick) begin
            if (two_stop_q) begin
              state <= STOP2;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        STOP2: begin
          if (bit_tick) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [3:0] baud_select = 4'b1011;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       busy, done, tx;

  uart_tx_ctrl_if bus();

  uart_tx_ctrl dut (
    .clk         (clk),
    .rstb        (rstb),
    .bus         (bus),
    .baud_select (baud_select),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .two_stop    (two_stop),
    .busy        (busy),
    .done        (done),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         n;
    int         len;
    bit         has_par;
    bit         par;
  } frame_t;

  typedef struct {
    logic [3:0] baud;
    logic       pe;
    logic       po;
    logic       ts;
    logic [7:0] data;
    int         n;
    int         len;
    bit         par;
  } vec_t;

  frame_t sb_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: on each start bit, pop the expected frame and compare tx/busy/done
  // every cycle of every bit, then the done cycle. A reset aborts the frame.
  initial begin : monitor
    frame_t     f;
    logic [11:0] bits;
    logic [2:0] s, e, cur;
    bit         bad, aborted;
    forever begin
      @(negedge clk);
      if (rstb === 1'b1 && tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_frame", tx, 1'b1);
          while (tx !== 1'b1) @(negedge clk);
        end else begin
          f = sb_q.pop_front();
          mon_active = 1'b1;
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
          if (f.has_par) bits[9] = f.par;
          bad = 1'b0;
          aborted = 1'b0;
          cur = '0;
          for (int k = 0; k < f.len; k++) begin
            if (k > 0) @(negedge clk);
            if (rstb !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            s = {tx, busy, done};
            e = {bits[k / f.n], 1'b1, 1'b0};
            if (!bad) begin
              cur = s;
              if (s !== e) bad = 1'b1;
            end
            if (k % f.n == f.n - 1) begin
              check($sformatf("frame%02h_bit%0d_tx_busy_done", f.data, k / f.n), cur, e);
              bad = 1'b0;
            end
          end
          if (!aborted) begin
            @(negedge clk);
            check($sformatf("frame%02h_end_done_busy_tx_rdy", f.data),
                  {done, busy, tx, bus.tx_ready}, 4'b1011);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] b, input logic pe, input logic po, input logic ts,
                      input logic [7:0] d, input int n, input int len, input bit par);
    frame_t f;
    @(negedge clk);
    baud_select  = b;
    parity_en    = pe;
    parity_odd   = po;
    two_stop     = ts;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    f.data = d; f.n = n; f.len = len; f.has_par = pe; f.par = par;
    sb_q.push_back(f);
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((sb_q.size() != 0 || mon_active || bus.tx_ready !== 1'b1) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout waited=%0d cycles required idle within %0d", c, budget);
    end
  endtask

  vec_t vecs[7];

  initial begin : main
    int c;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    vecs[0] = '{4'b1011, 1'b0, 1'b0, 1'b0, 8'hA5, 54,  540,  1'b0};
    vecs[1] = '{4'b1011, 1'b1, 1'b0, 1'b0, 8'hA5, 54,  594,  1'b0};
    vecs[2] = '{4'b1011, 1'b1, 1'b1, 1'b0, 8'hA5, 54,  594,  1'b1};
    vecs[3] = '{4'b1011, 1'b1, 1'b0, 1'b0, 8'h07, 54,  594,  1'b1};
    vecs[4] = '{4'b1011, 1'b1, 1'b1, 1'b0, 8'h07, 54,  594,  1'b0};
    vecs[5] = '{4'b1010, 1'b0, 1'b0, 1'b1, 8'h5A, 109, 1199, 1'b0};
    vecs[6] = '{4'b1001, 1'b1, 1'b1, 1'b1, 8'hC3, 217, 2604, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_tx_busy_done_rdy", {tx, busy, done, bus.tx_ready}, 4'b1001);
    rstb = 1'b1;
    @(negedge clk);
    check("post_reset_tx_busy_done_rdy", {tx, busy, done, bus.tx_ready}, 4'b1001);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].baud, vecs[v].pe, vecs[v].po, vecs[v].ts, vecs[v].data,
           vecs[v].n, vecs[v].len, vecs[v].par);
      wait_idle(5000);
    end

    // tx_start mid-frame is ignored
    send(4'b1011, 1'b0, 1'b0, 1'b0, 8'hA5, 54, 540, 1'b0);
    repeat (200) @(negedge clk);
    check("midframe_tx_ready", bus.tx_ready, 1'b0);
    bus.tx_data  = 8'h3C;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_idle(2000);
    repeat (100) @(negedge clk);
    check("no_queued_frame_tx", tx, 1'b1);

    // accept in the done cycle: start bit directly after stop bit
    send(4'b1011, 1'b0, 1'b0, 1'b0, 8'hA5, 54, 540, 1'b0);
    c = 0;
    while (done !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("b2b_done_seen", done, 1'b1);
    begin
      frame_t f;
      bus.tx_data  = 8'h3C;
      bus.tx_start = 1'b1;
      f.data = 8'h3C; f.n = 54; f.len = 540; f.has_par = 1'b0; f.par = 1'b0;
      sb_q.push_back(f);
    end
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("b2b_start_tx_busy", {tx, busy}, 2'b01);
    wait_idle(2000);

    // async reset during data bit 3
    send(4'b1011, 1'b0, 1'b0, 1'b0, 8'hA5, 54, 540, 1'b0);
    repeat (54 * 4 + 20) @(negedge clk);
    check("pre_reset_data_bit3", tx, 1'b0);
    #2 rstb = 1'b0;
    #1 check("async_reset_tx_busy_done_rdy", {tx, busy, done, bus.tx_ready}, 4'b1001);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("after_reset_release_tx", tx, 1'b1);
    send(4'b1011, 1'b0, 1'b0, 1'b0, 8'h3C, 54, 540, 1'b0);
    wait_idle(2000);

    // reserved baud code, config changed mid-frame
    send(4'b1111, 1'b0, 1'b0, 1'b0, 8'h55, 5208, 52080, 1'b0);
    baud_select = 4'b1011;
    parity_en   = 1'b1;
    two_stop    = 1'b1;
    repeat (3 * 5208 + 100) @(negedge clk);
    check("slow_baud_data_bit2_tx_busy", {tx, busy}, 2'b11);
    #2 rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    parity_en = 1'b0;
    two_stop  = 1'b0;
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller. Accepts a byte on a valid/ready handshake and serialises it on `tx`, LSB first: start bit, 8 data bits, optional parity, then 1 or 2 stop bits. Bit timing comes from an internal baud-period counter programmed by `baud_select`. It sits between the host-side register interface and the TX pin, and it sequences the bit-period counter: it starts the counter, stops it and reloads it per bit.

Parameters:
- DATA_BITS, 8, data bits per frame (fixed at 8; exposed for bench readability only).
- CNT_W, 18, bit-period counter width; must hold 166667.

Ports:
- clk, input, 1, system clock (50 MHz nominal).
- rstb, input, 1, asynchronous active-low reset.
- baud_select, input, 4, baud code; sampled at frame accept.
- parity_en, input, 1, 1 = insert a parity bit; sampled at accept.
- parity_odd, input, 1, 1 = odd parity, 0 = even; sampled at accept.
- two_stop, input, 1, 1 = two stop bits; sampled at accept.
- tx_start, input, 1, request valid.
- tx_data, input, 8, byte to send; sampled at accept.
- tx_ready, output, 1, high in IDLE only.
- busy, output, 1, high from the cycle after accept until return to IDLE.
- done, output, 1, one-cycle pulse at the end of the last stop bit.
- tx, output, 1, serial line; idles high.

Behaviour:
- Reset (async, rstb=0) forces these values immediately, whatever the state, including mid-frame:
  - state=IDLE, tx=1, busy=0, done=0, tx_ready=1;
  - counter=0; all latched config and data cleared.
- Baud table, N = clock cycles per bit:
  - 0000:166667, 0001:41667, 0010:20833, 0011:10417
  - 0100:5208, 0101:2604, 0110:1302, 0111:868
  - 1000:434, 1001:217, 1010:109, 1011:54
  - 1100-1111: 5208
- Accept condition: tx_start=1 while IDLE, at a clk edge.
  - That edge latches tx_data, N, parity_en, parity_odd and two_stop.
  - The state moves to START and the counter clears.
  - tx_start is ignored in any other state; no queueing.
- Bit counter:
  - Counts 0..N-1 while state≠IDLE. bit_tick = (counter==N-1).
  - On bit_tick the counter returns to 0.
  - In IDLE the counter holds 0.
  - Each serial bit is therefore held exactly N cycles.
- States and tx value:
  - IDLE (tx=1)
  - START (tx=0)
  - DATA (tx=shreg[0]; shift right on tick; bit index 0..7)
  - PARITY (tx=p)
  - STOP1 (tx=1)
  - STOP2 (tx=1)
- Transitions, all on bit_tick:
  - START→DATA.
  - DATA stays in DATA until index 7 ticks, then → PARITY if parity_en, else → STOP1.
  - PARITY→STOP1.
  - STOP1 → STOP2 if two_stop, else → IDLE.
  - STOP2→IDLE.
- tx is registered. The first start-bit cycle on `tx` is the cycle after the accept edge.
- Parity: p = XOR of the latched byte, XOR parity_odd.
- done=1 for exactly one cycle: the first IDLE cycle after the final tick. tx_ready rises in that same cycle.
- A new tx_start in the done cycle is accepted, giving back-to-back frames with no idle gap beyond the stop bits.
- Frame length in cycles = N × (10 + parity_en + two_stop).
- Mid-frame changes to baud_select or to the config inputs have no effect on the current frame.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - the 16-entry baud divisor table as constants plus a lookup function;
  - CNT_W.
- Sub-module baud_period_cnt contains the counter and tick compare.
  - Inputs: clk, rstb, run, N.
  - Output: bit_tick.
  - The FSM drives run=(state≠IDLE) and holds N stable per frame.

Test Plan:
- Basic frame: baud_select=1011 (N=54), tx_data=8'hA5, no parity, one stop.
  - tx=0 for 54 cycles, then bits 1,0,1,0,0,1,0,1 at 54 cycles each, then 1.
  - done pulses 540 cycles after the first start-bit cycle.
  - busy is high for exactly 540 cycles.
- Parity: same byte, parity_en=1.
  - parity_odd=0 gives a parity bit of 0.
  - parity_odd=1 gives 1.
  - Frame is 594 cycles.
  - Repeat with 8'h07 (parity even=1, odd=0).
- Two stop bits: two_stop=1, baud_select=1010 (N=109).
  - Stop high for 218 cycles.
  - Frame = 1199 cycles.
  - done occurs only after STOP2.
- Handshake:
  - Pulse tx_start again mid-frame with 8'h3C: ignored, and the original byte completes.
  - Assert tx_start in the done cycle with 8'h3C: the start bit follows the stop bit with no extra idle cycle.
- Reset mid-frame: drop rstb during DATA bit 3.
  - tx=1, busy=0, tx_ready=1 within the same cycle (async).
  - After release, a new frame sends correctly from START.
- Invalid baud code: baud_select=1111 with 8'h55. Each bit lasts 5208 cycles; also check that changing baud_select mid-frame does not alter the bit width.
